// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (MEM stage + loader).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuGnt,
  output logic              CpuDone,
  output logic [DATA_W-1:0] CpuRData,
  output logic              CpuStall,
  input  logic              LdReq,
  input  logic              LdWe,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdWData,
  output logic              LdGnt,
  output logic              LdDone,
  output logic [DATA_W-1:0] LdRData,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              AddrErr
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;

  logic win_ld;
  logic we_q;
  logic err_q;

  logic              any_req;
  logic              launch;
  logic              pick_ld;
  logic              sel_we;
  logic              sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_val;

`ifdef DMEM_ARB_RR_EN
  logic prio_ld;
`endif

  always_comb begin
    any_req = CpuReq | LdReq;
    launch  = any_req & ((state == IDLE) | (state == RESP));
`ifdef DMEM_ARB_RR_EN
    pick_ld = LdReq & (~CpuReq | prio_ld);
`else
    pick_ld = LdReq & ~CpuReq;
`endif
    sel_we    = pick_ld ? LdWe    : CpuWe;
    sel_addr  = pick_ld ? LdAddr  : CpuAddr;
    sel_wdata = pick_ld ? LdWData : CpuWData;
    sel_ok    = sel_addr[ADDR_W-1:DEPTH_LOG2] == '0;
    rd_val    = err_q ? '0 : MemRData;
  end

  // Stall drops in the Done cycle so the MEM stage can advance.
  assign CpuStall = (CpuReq | ((state != IDLE) & ~win_ld)) & ~CpuDone;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      win_ld   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      CpuGnt   <= 1'b0;
      CpuDone  <= 1'b0;
      CpuRData <= '0;
      LdGnt    <= 1'b0;
      LdDone   <= 1'b0;
      LdRData  <= '0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      AddrErr  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      prio_ld  <= 1'b0;
`endif
    end else begin
      CpuGnt   <= 1'b0;
      LdGnt    <= 1'b0;
      CpuDone  <= 1'b0;
      LdDone   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      AddrErr  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (any_req) state <= BUSY;
        end
        BUSY: begin
          state   <= RESP;
          CpuDone <= ~win_ld;
          LdDone  <= win_ld;
          AddrErr <= err_q;
          if (~we_q) begin
            if (win_ld) LdRData  <= rd_val;
            else        CpuRData <= rd_val;
          end
        end
        RESP: begin
          state <= any_req ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (launch) begin
        win_ld   <= pick_ld;
        we_q     <= sel_we;
        err_q    <= ~sel_ok;
        MemAddr  <= sel_addr;
        MemWData <= sel_wdata;
        MemRead  <= ~sel_we & sel_ok;
        MemWrite <= sel_we & sel_ok;
        CpuGnt   <= ~pick_ld;
        LdGnt    <= pick_ld;
`ifdef DMEM_ARB_RR_EN
        prio_ld  <= ~pick_ld;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: queued expectations checked by
// independent grant/done monitors against a negedge memory model.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWe, LdReq, LdWe;
  logic [31:0] CpuAddr, CpuWData, LdAddr, LdWData;
  logic        CpuGnt, CpuDone, CpuStall, LdGnt, LdDone;
  logic [31:0] CpuRData, LdRData;
  logic        MemRead, MemWrite, AddrErr;
  logic [31:0] MemAddr, MemWData;
  logic [31:0] MemRData = '0;

  logic [31:0] mem [256];

  typedef struct {
    bit          ld;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
  } gexp_t;

  typedef struct {
    bit          ld;
    bit          chk;
    logic [31:0] data;
    bit          err;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;

  dmem_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr),
    .CpuWData(CpuWData), .CpuGnt(CpuGnt), .CpuDone(CpuDone),
    .CpuRData(CpuRData), .CpuStall(CpuStall),
    .LdReq(LdReq), .LdWe(LdWe), .LdAddr(LdAddr),
    .LdWData(LdWData), .LdGnt(LdGnt), .LdDone(LdDone),
    .LdRData(LdRData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .AddrErr(AddrErr)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    mem[0] = 32'd15;
    mem[1] = 32'd8;
  end

  always @(negedge Clk) begin
    if (MemWrite) mem[MemAddr[7:0]] <= MemWData;
    if (MemRead) MemRData <= mem[MemAddr[7:0]];
    if (MemWrite) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string n, input logic [63:0] a,
                       input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge Clk) begin
    gexp_t g;
    dexp_t d;
    if (CpuGnt | LdGnt) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", 1, 0);
      end else begin
        g = gq.pop_front();
        check("gnt_who", {CpuGnt, LdGnt}, g.ld ? 2'b01 : 2'b10);
        check("mem_read", MemRead, g.rd);
        check("mem_write", MemWrite, g.wr);
        check("mem_addr", MemAddr, g.addr);
      end
    end
    if (CpuDone | LdDone) begin
      if (dq.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        d = dq.pop_front();
        check("done_who", {CpuDone, LdDone}, d.ld ? 2'b01 : 2'b10);
        check("addr_err", AddrErr, d.err);
        if (d.chk) check("rdata", d.ld ? LdRData : CpuRData, d.data);
      end
      check("gnt_done_same", (CpuGnt & CpuDone) | (LdGnt & LdDone), 0);
    end
    if (AddrErr === 1'b1 && !(CpuDone | LdDone))
      check("err_no_done", 1, 0);
  end

  task automatic do_req(input bit ld, input bit we, input logic [31:0] a,
                        input logic [31:0] d, output int gc);
    int n;
    n = 0;
    gc = -100;
    if (ld) begin
      LdReq = 1; LdWe = we; LdAddr = a; LdWData = d;
    end else begin
      CpuReq = 1; CpuWe = we; CpuAddr = a; CpuWData = d;
    end
    forever begin
      @(negedge Clk);
      n++;
      if (ld ? LdGnt : CpuGnt) begin
        gc = cyc;
        break;
      end
      if (n > 20) begin
        check("gnt_timeout", 1, 0);
        break;
      end
    end
    @(posedge Clk);
    #1;
    if (ld) LdReq = 0;
    else CpuReq = 0;
  endtask

  task automatic idle();
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pg(input bit ld, input bit rd, input bit wr,
                    input logic [31:0] a);
    gexp_t g;
    g.ld = ld; g.rd = rd; g.wr = wr; g.addr = a;
    gq.push_back(g);
  endtask

  task automatic pd(input bit ld, input bit chk, input logic [31:0] v,
                    input bit err);
    dexp_t d;
    d.ld = ld; d.chk = chk; d.data = v; d.err = err;
    dq.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, gc, g_cpu, g_ld, scnt, w0;
    int gl [4];
    Reset = 1;
    CpuReq = 0; CpuWe = 0; CpuAddr = '0; CpuWData = '0;
    LdReq = 0; LdWe = 0; LdAddr = '0; LdWData = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_ctl",
          {MemRead, MemWrite, CpuGnt, LdGnt, CpuDone, LdDone,
           AddrErr, CpuStall}, 0);
    check("reset_addr", MemAddr, 0);
    check("reset_rdata", {CpuRData, LdRData}, 0);
    @(posedge Clk);
    #1;
    Reset = 0;
    idle();

    // single CPU read
    pg(0, 1, 0, 5); pd(0, 1, 5, 0);
    k = cyc;
    scnt = 0;
    fork
      do_req(0, 0, 5, 0, gc);
      repeat (4) @(negedge Clk) if (CpuStall) scnt++;
    join
    check("t1_gnt_lat", gc - k, 1);
    check("t1_stall_cycles", scnt, 2);
    idle();

    // loader write then CPU readback
    w0 = wr_cnt;
    pg(1, 0, 1, 35); pd(1, 0, 0, 0);
    do_req(1, 1, 35, 77, gc);
    pg(0, 1, 0, 35); pd(0, 1, 77, 0);
    do_req(0, 0, 35, 0, gc);
    idle();
    check("t2_write_cycles", wr_cnt - w0, 1);

    // simultaneous requests
`ifdef DMEM_ARB_RR_EN
    pg(1, 1, 0, 1); pg(0, 1, 0, 0);
    pd(1, 1, 8, 0); pd(0, 1, 15, 0);
`else
    pg(0, 1, 0, 0); pg(1, 1, 0, 1);
    pd(0, 1, 15, 0); pd(1, 1, 8, 0);
`endif
    fork
      do_req(0, 0, 0, 0, g_cpu);
      do_req(1, 0, 1, 0, g_ld);
    join
`ifdef DMEM_ARB_RR_EN
    check("t3_gap", g_cpu - g_ld, 2);
`else
    check("t3_gap", g_ld - g_cpu, 2);
`endif
    idle();

    // out-of-range read
    pg(0, 0, 0, 300); pd(0, 1, 0, 1);
    do_req(0, 0, 300, 0, gc);
    idle();

    // reset during BUSY
    pg(0, 1, 0, 7);
    CpuReq = 1; CpuWe = 0; CpuAddr = 7;
    @(posedge Clk);
    #1;
    Reset = 1;
    CpuReq = 0;
    @(posedge Clk);
    #1;
    Reset = 0;
    @(negedge Clk);
    check("t5_ctl_after_reset", {CpuDone, MemRead, CpuGnt, CpuStall}, 0);
    idle();
    pg(0, 1, 0, 7); pd(0, 1, 7, 0);
    do_req(0, 0, 7, 0, gc);
    idle();

    // back-to-back loader writes, then readback
    for (int i = 0; i < 4; i++) begin
      pg(1, 0, 1, 10 + i); pd(1, 0, 0, 0);
      do_req(1, 1, 10 + i, 200 + i, gl[i]);
    end
    for (int i = 1; i < 4; i++) check("t6_gnt_gap", gl[i] - gl[i-1], 2);
    for (int i = 0; i < 4; i++) begin
      pg(1, 1, 0, 10 + i); pd(1, 1, 200 + i, 0);
      do_req(1, 0, 10 + i, 0, gc);
    end

    repeat (6) @(negedge Clk);
    check("gq_drained", gq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
